// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register slice.
// Contents:
//   PIPE_NOP  - default bubble value that a stage holds when it is empty
//   clog2_cnt - width of a counter that must hold values 0..depth inclusive
package pipe_pkg;

  localparam logic [63:0] PIPE_NOP = 64'h0;

  // Smallest width able to represent every count from 0 up to and including
  // depth. The result is never below 1, so a one-stage chain still gets a
  // usable occupancy port.
  function automatic int clog2_cnt(input int depth);
    int w;
    w = 1;
    while ((1 << w) < (depth + 1)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One stage of the elastic pipeline: a data register plus its valid bit.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   flush       - squashes the stage at the next edge
//   up_valid    - upstream stage (or chain input) holds an item
//   up_data     - upstream payload
//   down_ready  - downstream stage (or chain output) can take our item
//   valid, data - registered contents of this stage
//   ready       - this stage loads from upstream at the next edge
module elastic_pipe_stage
  import pipe_pkg::*;
#(
  parameter int            SZ  = 64,
  parameter logic [SZ-1:0] NOP = SZ'(PIPE_NOP)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          up_valid,
  input  logic [SZ-1:0] up_data,
  input  logic          down_ready,
  output logic          valid,
  output logic [SZ-1:0] data,
  output logic          ready
);

  logic move;

  // A stage may load when it is empty or when its own item leaves this
  // cycle; that is what lets bubbles collapse instead of stalling the chain.
  assign move  = valid & down_ready;
  assign ready = ~valid | move;

  // Reset beats flush beats normal loading. An empty upstream loads a bubble,
  // so an idle stage always carries NOP rather than stale data.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= 1'b0;
      data  <= NOP;
    end else if (ready) begin
      valid <= up_valid;
      data  <= up_valid ? up_data : NOP;
    end
  end

endmodule

// File: rtl/elastic_pipeline_register.sv
// Elastic pipeline register chain: DEPTH stages of SZ bits, each with its own
// valid bit, handshaking valid/ready at both ends and flushable in one cycle.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   in_valid, in_data    - upstream item offered to stage 0
//   in_ready             - chain accepts in_data this cycle
//   out_valid, out_data  - registered contents of the last stage
//   out_ready            - downstream consumes out_data this cycle
//   flush                - squash every stage at the next edge
//   occupancy            - number of stages currently holding an item
module elastic_pipeline_register
  import pipe_pkg::*;
#(
  parameter int            SZ    = 64,
  parameter int            DEPTH = 1,
  parameter logic [SZ-1:0] NOP   = SZ'(PIPE_NOP)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [SZ-1:0]                 in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [SZ-1:0]                 out_data,
  input  logic                          out_ready,
  input  logic                          flush,
  output logic [clog2_cnt(DEPTH)-1:0]   occupancy
);

  localparam int OW = clog2_cnt(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("elastic_pipeline_register: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] stage_valid;
  logic             head_ready;

  // Stage 0 faces the input, stage DEPTH-1 faces the output. Valid/data
  // flow forward from the previous stage; ready flows backward from the
  // next stage, so out_ready ripples combinationally down to in_ready.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic          up_valid;
    logic [SZ-1:0] up_data;
    logic          down_ready;
    logic          valid;
    logic [SZ-1:0] data;
    logic          ready;

    if (i == 0) begin : g_head
      assign up_valid   = in_valid;
      assign up_data    = in_data;
      assign head_ready = ready;
    end else begin : g_mid
      assign up_valid = g_stage[i-1].valid;
      assign up_data  = g_stage[i-1].data;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign down_ready = out_ready;
    end else begin : g_link
      assign down_ready = g_stage[i+1].ready;
    end

    elastic_pipe_stage #(
      .SZ  (SZ),
      .NOP (NOP)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .down_ready (down_ready),
      .valid      (valid),
      .data       (data),
      .ready      (ready)
    );

    assign stage_valid[i] = valid;
  end

  // During a flush nothing may be taken in: the flushing edge would drop it.
  assign in_ready  = head_ready & ~flush;
  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = g_stage[DEPTH-1].data;

  // Occupancy is a plain popcount of the registered valid bits.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OW'(stage_valid[i]);
    end
  end

endmodule

// File: tb/tb_elastic_pipeline_register.sv
// Self-checking bench for elastic_pipeline_register. A DEPTH=3 instance is
// compared cycle by cycle against a queue-of-items reference model; a DEPTH=1
// instance is checked for single-cycle latency at full throughput.
module tb_elastic_pipeline_register;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       flush;
  logic [1:0] occupancy;

  logic       d1_in_valid;
  logic [7:0] d1_in_data;
  logic       d1_in_ready;
  logic       d1_out_valid;
  logic [7:0] d1_out_data;
  logic       d1_out_ready;
  logic       d1_flush;
  logic [0:0] d1_occupancy;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: items oldest first, each with the stage index it sits in.
  logic [7:0] q_data[$];
  int         q_pos[$];
  logic [7:0] obs_out[$];

  // {in_ready, out_valid, out_data, occupancy} as observed / as predicted.
  logic [11:0] obs_vec;
  logic [11:0] exp_vec;

  always #5 clk = ~clk;

  elastic_pipeline_register #(.SZ(8), .DEPTH(D), .NOP(8'h00)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy)
  );

  elastic_pipeline_register #(.SZ(8), .DEPTH(1), .NOP(8'h00)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (d1_in_valid),
    .in_data   (d1_in_data),
    .in_ready  (d1_in_ready),
    .out_valid (d1_out_valid),
    .out_data  (d1_out_data),
    .out_ready (d1_out_ready),
    .flush     (d1_flush),
    .occupancy (d1_occupancy)
  );

  // Drives one cycle into the DEPTH=3 instance, samples its outputs before the
  // edge, predicts them from the model, then advances the model past the edge.
  // Items advance one slot per cycle into any slot that will be free; the head
  // leaves only when out_ready is high.
  task automatic applyStimulus(input logic iv, input logic [7:0] id,
                               input logic ordy, input logic fl);
    logic [7:0] nd[$];
    int         np[$];
    int         limit;
    logic       ev;
    logic [7:0] ed;
    logic       eir;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    ev = 1'b0;
    ed = 8'h00;
    foreach (q_pos[k]) begin
      if (q_pos[k] == D - 1) begin
        ev = 1'b1;
        ed = q_data[k];
      end
    end
    limit = D;
    foreach (q_pos[k]) begin
      if (q_pos[k] == D - 1 && ordy) begin
        limit = D;
      end else if (q_pos[k] + 1 < limit && q_pos[k] != D - 1) begin
        np.push_back(q_pos[k] + 1);
        nd.push_back(q_data[k]);
        limit = q_pos[k] + 1;
      end else begin
        np.push_back(q_pos[k]);
        nd.push_back(q_data[k]);
        limit = q_pos[k];
      end
    end
    eir = !fl && (limit > 0);
    exp_vec = {eir, ev, ed, 2'(q_pos.size())};
    obs_vec = {in_ready, out_valid, out_data, occupancy};
    if (out_valid && ordy) obs_out.push_back(out_data);
    if (iv && eir) begin
      np.push_back(0);
      nd.push_back(id);
    end
    @(posedge clk);
    if (fl) begin
      q_pos.delete();
      q_data.delete();
    end else begin
      q_pos  = np;
      q_data = nd;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q_pos.delete();
    q_data.delete();
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_data, occupancy} !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %h expected %h",
               {in_ready, out_valid, out_data, occupancy}, {1'b1, 1'b0, 8'h00, 2'd0});
    end
    n_vec++;
    if ({d1_in_ready, d1_out_valid, d1_out_data, d1_occupancy} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_state_d1: got %h expected %h",
               {d1_in_ready, d1_out_valid, d1_out_data, d1_occupancy}, {1'b1, 1'b0, 8'h00, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [7:0] want;
    for (int c = 0; c < 7; c++) begin
      applyStimulus(c < 3, 8'(8'hA1 + c), 1'b1, 1'b0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL stream_model c=%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      want = 8'(8'hA1 + c - 3);
      if (c >= 3 && c <= 5) begin
        n_vec++;
        if (obs_vec[10:2] !== {1'b1, want}) begin
          n_fail++;
          $display("[TB] FAIL stream_latency c=%0d: got %h expected %h", c, obs_vec[10:2], {1'b1, want});
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int idx;
    logic ordy;
    idx = 0;
    obs_out.delete();
    for (int c = 0; c < 12; c++) begin
      ordy = (c >= 4);
      applyStimulus(idx < 4, 8'(8'hB1 + idx), ordy, 1'b0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL backpressure_model c=%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c == 3) begin
        n_vec++;
        if ({obs_vec[11], obs_vec[1:0]} !== {1'b0, 2'd3}) begin
          n_fail++;
          $display("[TB] FAIL backpressure_full: got ready/occ %h expected %h",
                   {obs_vec[11], obs_vec[1:0]}, {1'b0, 2'd3});
        end
      end
      if (idx < 4 && obs_vec[11]) idx++;
    end
    n_vec++;
    if (obs_out.size() != 4) begin
      n_fail++;
      $display("[TB] FAIL backpressure_count: got %0d items expected 4", obs_out.size());
    end
    foreach (obs_out[k]) begin
      n_vec++;
      if (obs_out[k] !== 8'(8'hB1 + k)) begin
        n_fail++;
        $display("[TB] FAIL backpressure_order k=%0d: got %h expected %h", k, obs_out[k], 8'(8'hB1 + k));
      end
    end
  endtask

  task automatic test_bubble_collapse();
    logic [3:0] pat;
    pat = 4'b1001;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(c < 4 && pat[3 - (c % 4)], (c == 0) ? 8'hC1 : 8'hC2, c >= 5, 1'b0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL bubble_model c=%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c == 5) begin
        n_vec++;
        if (obs_vec[10:0] !== {1'b1, 8'hC1, 2'd2}) begin
          n_fail++;
          $display("[TB] FAIL bubble_first: got %h expected %h", obs_vec[10:0], {1'b1, 8'hC1, 2'd2});
        end
      end
      if (c == 6) begin
        n_vec++;
        if (obs_vec[10:2] !== {1'b1, 8'hC2}) begin
          n_fail++;
          $display("[TB] FAIL bubble_second: got %h expected %h", obs_vec[10:2], {1'b1, 8'hC2});
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 8'(8'hE1 + c), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hD1, 1'b0, 1'b1);
    n_vec++;
    if ({obs_vec[11], obs_vec[1:0]} !== {1'b0, 2'd3}) begin
      n_fail++;
      $display("[TB] FAIL flush_cycle: got ready/occ %h expected %h", {obs_vec[11], obs_vec[1:0]}, {1'b0, 2'd3});
    end
    applyStimulus(1'b1, 8'hD1, 1'b0, 1'b0);
    n_vec++;
    if (obs_vec !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL flush_after: got %h expected %h", obs_vec, {1'b1, 1'b0, 8'h00, 2'd0});
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    n_vec++;
    if (obs_vec[1:0] !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL flush_reaccept: got occupancy %0d expected 1", obs_vec[1:0]);
    end
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midstream();
    applyStimulus(1'b1, 8'h71, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h72, 1'b0, 1'b0);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h73;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    q_pos.delete();
    q_data.delete();
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_data, occupancy} !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_midstream: got %h expected %h",
               {in_ready, out_valid, out_data, occupancy}, {1'b1, 1'b0, 8'h00, 2'd0});
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 19) == 0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL random_model c=%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_depth1();
    logic [7:0] prev;
    prev = 8'h00;
    for (int c = 0; c < 6; c++) begin
      d1_in_valid  = 1'b1;
      d1_in_data   = 8'(8'h50 + c);
      d1_out_ready = 1'b1;
      #1;
      n_vec++;
      if ({d1_in_ready, d1_out_valid, d1_out_data, d1_occupancy} !== {1'b1, c > 0, prev, c > 0}) begin
        n_fail++;
        $display("[TB] FAIL depth1_stream c=%0d: got %h expected %h", c,
                 {d1_in_ready, d1_out_valid, d1_out_data, d1_occupancy}, {1'b1, c > 0, prev, c > 0});
      end
      prev = d1_in_data;
      @(posedge clk);
      @(negedge clk);
    end
    d1_in_data   = 8'h60;
    d1_out_ready = 1'b0;
    #1;
    n_vec++;
    if ({d1_in_ready, d1_out_valid, d1_out_data} !== {1'b0, 1'b1, 8'h55}) begin
      n_fail++;
      $display("[TB] FAIL depth1_stall: got %h expected %h",
               {d1_in_ready, d1_out_valid, d1_out_data}, {1'b0, 1'b1, 8'h55});
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({d1_out_valid, d1_out_data} !== {1'b1, 8'h55}) begin
      n_fail++;
      $display("[TB] FAIL depth1_hold: got %h expected %h", {d1_out_valid, d1_out_data}, {1'b1, 8'h55});
    end
    d1_in_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = 8'h00;
    out_ready    = 1'b0;
    flush        = 1'b0;
    d1_in_valid  = 1'b0;
    d1_in_data   = 8'h00;
    d1_out_ready = 1'b0;
    d1_flush     = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble_collapse();
    test_flush();
    test_reset_midstream();
    test_random();
    test_depth1();
    $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
